// File: rtl/sound_pkg.sv
// Shared constants for the sound output block: modulator mode encodings and
// the mix-width helper used to size the per-bus adders and modulators.
package sound_pkg;

    localparam logic MODE_SDM = 1'b0;
    localparam logic MODE_PWM = 1'b1;

    // Width of a bus that must hold the sum of nch unsigned dw-bit samples.
    function automatic int mix_width(input int nch, input int dw);
        return dw + $clog2(nch);
    endfunction

endpackage

// File: rtl/sound_mod.sv
// Per-bus 1-bit DAC: a first-order sigma-delta and a triangle PWM both run
// continuously, and a registered mux picks which one drives the pin.
module sound_mod
    import sound_pkg::*;
#(
    parameter int SW = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [SW-1:0] mix,
    input  logic          mode,
    input  logic [SW:0]   cnt,
    output logic          sound
);

    logic [SW-1:0] acc;
    logic          sdm_bit;
    logic          pwm_bit;
    logic          phase;
    logic [SW-1:0] saw;
    logic [SW-1:0] ramp;

    // Falling ramp then rising ramp, so the high run straddles the phase boundary.
    assign phase = cnt[SW];
    assign saw   = cnt[SW-1:0];
    assign ramp  = phase ? saw : ~saw;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            sdm_bit <= 1'b0;
            pwm_bit <= 1'b0;
            sound   <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            {sdm_bit, acc} <= {1'b0, acc} + {1'b0, mix};
            pwm_bit        <= (ramp < mix);
            sound          <= (mode == MODE_PWM) ? pwm_bit : sdm_bit;
        end
    end

endmodule

// File: rtl/sound_mix_dac.sv
// Multi-channel covox/beeper sound block: sample registers, panned L/R mix
// adders and a shared PWM counter feeding one modulator per output bus.
module sound_mix_dac
    import sound_pkg::*;
#(
    parameter  int NCH = 4,
    parameter  int DW  = 8,
    localparam int SW  = mix_width(NCH, DW)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [DW-1:0]  din,
    input  logic [NCH-1:0] ch_wr,
    input  logic           beeper_wr,
    input  logic           beeper_mux,
    input  logic [NCH-1:0] pan_l,
    input  logic [NCH-1:0] pan_r,
    input  logic           mode,
    output logic           sound_l,
    output logic           sound_r,
    output logic [SW-1:0]  mix_l,
    output logic [SW-1:0]  mix_r
);

    logic [DW-1:0] ch_val [NCH];
    logic [SW-1:0] sum_l;
    logic [SW-1:0] sum_r;
    logic [SW:0]   cnt;
    logic          beep_bit;

    assign beep_bit = beeper_mux ? din[3] : din[4];

    // NOTE: the sample registers are a handful of flops, not a RAM, so they take the async reset too.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) ch_val[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_wr[i])
                    ch_val[i] <= din;
                else if (beeper_wr)
                    ch_val[i] <= {DW{beep_bit}};
            end
        end
    end

    // Sum cannot overflow: NCH full-scale samples fit in SW bits by construction.
    always_comb begin
        // NOTE: defaults first so no path leaves the sums unassigned (no latch);
        // blocking = is correct here because this is a running combinational total.
        sum_l = '0;
        sum_r = '0;
        for (int i = 0; i < NCH; i++) begin
            if (pan_l[i]) sum_l = sum_l + SW'(ch_val[i]);
            if (pan_r[i]) sum_r = sum_r + SW'(ch_val[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mix_l <= '0;
            mix_r <= '0;
            cnt   <= '0;
        end else begin
            mix_l <= sum_l;
            mix_r <= sum_r;
            cnt   <= cnt + 1'b1;
        end
    end

    // One counter for both buses keeps the L and R PWM carriers phase-aligned.
    sound_mod #(.SW(SW)) u_mod_l (
        .clk     (clk),
        .reset_n (reset_n),
        .mix     (mix_l),
        .mode    (mode),
        .cnt     (cnt),
        .sound   (sound_l)
    );

    sound_mod #(.SW(SW)) u_mod_r (
        .clk     (clk),
        .reset_n (reset_n),
        .mix     (mix_r),
        .mode    (mode),
        .cnt     (cnt),
        .sound   (sound_r)
    );

endmodule

// File: tb/tb_sound_mix_dac.sv
// Self-checking bench for sound_mix_dac: table vectors for the register/mix
// path, hand sequences for modulator timing, and randomized trials against a model.
module tb_sound_mix_dac;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int SW  = 10;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [DW-1:0]  din = '0;
    logic [NCH-1:0] ch_wr = '0;
    logic           beeper_wr = 1'b0;
    logic           beeper_mux = 1'b0;
    logic [NCH-1:0] pan_l = '0;
    logic [NCH-1:0] pan_r = '0;
    logic           mode = 1'b0;
    logic           sound_l;
    logic           sound_r;
    logic [SW-1:0]  mix_l;
    logic [SW-1:0]  mix_r;

    int checks = 0;
    int errors = 0;
    int model_ch [NCH];

    typedef struct {
        logic [3:0] wr;
        logic       bw;
        logic       mux;
        logic [7:0] d;
        logic [3:0] pl;
        logic [3:0] pr;
        int         exp_l;
        int         exp_r;
        logic       win;
    } vec_t;

    vec_t vecs [8];

    sound_mix_dac #(.NCH(NCH), .DW(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (din),
        .ch_wr      (ch_wr),
        .beeper_wr  (beeper_wr),
        .beeper_mux (beeper_mux),
        .pan_l      (pan_l),
        .pan_r      (pan_r),
        .mode       (mode),
        .sound_l    (sound_l),
        .sound_r    (sound_r),
        .mix_l      (mix_l),
        .mix_r      (mix_r)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic model_write(input logic [3:0] wr, input logic bw, input logic mux, input logic [7:0] d);
        for (int i = 0; i < NCH; i++) begin
            if (wr[i])
                model_ch[i] = d;
            else if (bw)
                model_ch[i] = (mux ? d[3] : d[4]) ? 255 : 0;
        end
    endtask

    function automatic int model_mix(input logic [3:0] pan);
        int s = 0;
        for (int i = 0; i < NCH; i++)
            if (pan[i]) s += model_ch[i];
        return s;
    endfunction

    task automatic do_write(input logic [3:0] wr, input logic bw, input logic mux, input logic [7:0] d);
        ch_wr      = wr;
        beeper_wr  = bw;
        beeper_mux = mux;
        din        = d;
        if (reset_n) model_write(wr, bw, mux, d);
        tick();
        ch_wr     = '0;
        beeper_wr = 1'b0;
    endtask

    task automatic count_ones(input int n, output int ones_l, output int ones_r);
        ones_l = 0;
        ones_r = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            ones_l += int'(sound_l);
            ones_r += int'(sound_r);
        end
    endtask

    initial begin
        int ol, or_;
        int rises;
        logic prev;
        logic found;

        vecs[0] = '{4'b0001, 1'b0, 1'b0, 8'h80, 4'hF, 4'h0, 128, 0, 1'b1};
        vecs[1] = '{4'b1111, 1'b0, 1'b0, 8'hFF, 4'hF, 4'hF, 1020, 1020, 1'b1};
        vecs[2] = '{4'b0000, 1'b1, 1'b0, 8'h08, 4'hF, 4'hF, 0, 0, 1'b0};
        vecs[3] = '{4'b0000, 1'b1, 1'b0, 8'h10, 4'hF, 4'hF, 1020, 1020, 1'b0};
        vecs[4] = '{4'b0100, 1'b1, 1'b1, 8'h08, 4'hF, 4'hF, 773, 773, 1'b0};
        vecs[5] = '{4'b0000, 1'b0, 1'b0, 8'h00, 4'b0100, 4'b1011, 8, 765, 1'b0};
        vecs[6] = '{4'b1010, 1'b0, 1'b0, 8'h33, 4'hF, 4'h0, 365, 0, 1'b1};
        vecs[7] = '{4'b0000, 1'b1, 1'b1, 8'h10, 4'hF, 4'hF, 0, 0, 1'b0};

        for (int i = 0; i < NCH; i++) model_ch[i] = 0;

        // Writes during reset must be ignored.
        pan_l = 4'hF;
        pan_r = 4'hF;
        ticks(2);
        do_write(4'hF, 1'b0, 1'b0, 8'hFF);
        ticks(3);
        check("rst_mix_l", mix_l, 0);
        check("rst_mix_r", mix_r, 0);
        check("rst_sound_l", sound_l, 0);
        check("rst_sound_r", sound_r, 0);
        reset_n = 1'b1;
        ticks(4);
        check("post_rst_mix_l", mix_l, 0);
        check("post_rst_mix_r", mix_r, 0);
        check("post_rst_sound_l", sound_l, 0);
        check("post_rst_sound_r", sound_r, 0);

        // Table vectors in sigma-delta mode; some rows also measure 1024-clk density.
        mode = 1'b0;
        for (int v = 0; v < 8; v++) begin
            pan_l = vecs[v].pl;
            pan_r = vecs[v].pr;
            do_write(vecs[v].wr, vecs[v].bw, vecs[v].mux, vecs[v].d);
            tick();
            check($sformatf("vec%0d_mix_l", v), mix_l, vecs[v].exp_l);
            check($sformatf("vec%0d_mix_r", v), mix_r, vecs[v].exp_r);
            if (vecs[v].win) begin
                ticks(4);
                count_ones(1024, ol, or_);
                check($sformatf("vec%0d_sdm_l", v), ol, vecs[v].exp_l);
                check($sformatf("vec%0d_sdm_r", v), or_, vecs[v].exp_r);
            end
        end

        // PWM with mix_l = 256: one contiguous 512-clk run per 2048-clk period.
        pan_l = 4'hF;
        pan_r = 4'h0;
        do_write(4'b0000, 1'b1, 1'b0, 8'h00);
        do_write(4'b0011, 1'b0, 1'b0, 8'h80);
        tick();
        check("pwm_mix_l", mix_l, model_mix(pan_l));
        mode = 1'b1;
        ticks(4);
        tick();
        prev  = sound_l;
        ol    = int'(sound_l);
        or_   = int'(sound_r);
        rises = 0;
        for (int k = 1; k <= 2048; k++) begin
            tick();
            if (!prev && sound_l) rises++;
            if (k < 2048) begin
                ol  += int'(sound_l);
                or_ += int'(sound_r);
            end
            prev = sound_l;
        end
        check("pwm_high_l", ol, 512);
        check("pwm_runs_l", rises, 1);
        check("pwm_r_silent", or_, 0);

        // Mode switch: inside the PWM low run, SDM ones (period 4) come and go on the next clk.
        found = 1'b0;
        prev  = sound_l;
        for (int k = 0; k < 4096 && !found; k++) begin
            tick();
            if (prev && !sound_l) found = 1'b1;
            prev = sound_l;
        end
        check("pwm_fall_seen", int'(found), 1);
        if (found) begin
            mode  = 1'b0;
            found = 1'b0;
            for (int k = 0; k < 16 && !found; k++) begin
                tick();
                if (sound_l) found = 1'b1;
            end
            check("sdm_one_seen", int'(found), 1);
            if (found) begin
                ticks(3);
                mode = 1'b1;
                tick();
                check("switch_to_pwm", sound_l, 0);
                mode = 1'b0;
                ticks(4);
                check("switch_to_sdm", sound_l, 1);
            end
        end

        // pan_r = 0 keeps the right bus silent in sigma-delta mode too.
        mode = 1'b0;
        ticks(4);
        count_ones(1024, ol, or_);
        check("sdm_l_256", ol, 256);
        check("sdm_r_silent", or_, 0);
        check("mix_r_zero", mix_r, 0);

        // Asynchronous reset while PWM output is high.
        mode  = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 4096 && !found; k++) begin
            tick();
            if (sound_l) found = 1'b1;
        end
        check("pwm_high_seen", int'(found), 1);
        reset_n = 1'b0;
        #1;
        check("async_rst_sound_l", sound_l, 0);
        check("async_rst_mix_l", mix_l, 0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < NCH; i++) model_ch[i] = 0;
        ticks(4);
        check("rerun_mix_l", mix_l, 0);
        check("rerun_sound_l", sound_l, 0);

        // Randomized register/pan traffic against the model.
        for (int n = 0; n < 40; n++) begin
            logic [3:0] wr;
            wr    = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            pan_l = 4'($urandom_range(0, 15));
            pan_r = 4'($urandom_range(0, 15));
            do_write(wr, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            tick();
            check($sformatf("rnd%0d_mix_l", n), mix_l, model_mix(pan_l));
            check($sformatf("rnd%0d_mix_r", n), mix_r, model_mix(pan_r));
        end

        // Randomized density checks for both modulators.
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < NCH; i++)
                do_write(4'(1 << i), 1'b0, 1'b0, 8'($urandom_range(0, 255)));
            pan_l = 4'($urandom_range(1, 15));
            pan_r = 4'($urandom_range(1, 15));
            mode  = 1'b0;
            ticks(5);
            count_ones(1024, ol, or_);
            check($sformatf("rnd_sdm%0d_l", t), ol, model_mix(pan_l));
            check($sformatf("rnd_sdm%0d_r", t), or_, model_mix(pan_r));
            mode = 1'b1;
            ticks(4);
            count_ones(2048, ol, or_);
            check($sformatf("rnd_pwm%0d_l", t), ol, 2 * model_mix(pan_l));
            check($sformatf("rnd_pwm%0d_r", t), or_, 2 * model_mix(pan_r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
